// File: rtl/i2c_txn_ctrl_pkg.sv
// Shared types for the I2C transaction controller: engine command codes and
// controller state encoding.
package i2c_txn_ctrl_pkg;

    typedef enum logic [2:0] {
        I2C_CMD_START     = 3'd0,
        I2C_CMD_WRITE     = 3'd1,
        I2C_CMD_READ_ACK  = 3'd2,
        I2C_CMD_READ_NACK = 3'd3,
        I2C_CMD_STOP      = 3'd4
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WR    = 3'd3,
        ST_RD    = 3'd4,
        ST_STOP  = 3'd5
    } txn_state_e;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    function automatic logic [BYTE_W-1:0] addr_byte(input logic [ADDR_W-1:0] addr,
                                                    input logic rd);
        return {addr, rd};
    endfunction

endpackage

// File: rtl/i2c_txn_ctrl_byte_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head and occupancy count.
// Overflowing pushes and underflowing pops are dropped.
module byte_fifo
    import i2c_txn_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [7:0]        push_data,
    input  logic              pop,
    output logic [7:0]        head,
    output logic [LEN_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LEN_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LEN_W'(1);
                2'b01:   level <= level - LEN_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/i2c_txn_ctrl.sv
// Sequences one I2C transaction (START, address, N data bytes, STOP) on the bit
// engine, with TX/RX byte FIFOs, sticky error status and a done interrupt.
module i2c_txn_ctrl
    import i2c_txn_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic [6:0]        dev_addr,
    input  logic              rw,
    input  logic [LEN_W-1:0]  len,
    input  logic              it_enable,
    input  logic              tx_we,
    input  logic [7:0]        tx_data,
    input  logic              rx_re,
    output logic [7:0]        rx_data,
    output logic [LEN_W-1:0]  tx_level,
    output logic [LEN_W-1:0]  rx_level,
    output logic              busy,
    output logic              done,
    output logic              nack_err,
    output logic              irq,
    output logic [2:0]        eng_cmd,
    output logic              eng_cmd_valid,
    output logic [7:0]        eng_tx,
    input  logic              eng_ready,
    input  logic              eng_done,
    input  logic              eng_ack,
    input  logic [7:0]        eng_rx
);

    txn_state_e        state_q, state_d;
    logic              wait_q, wait_d;
    logic              abort_q, abort_d;
    logic              nack_q, nack_d;
    logic              flag_q, flag_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  cnt_nx;
    logic [LEN_W-1:0]  len_clamped;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [LEN_W-1:0]  len_q;
    logic              latch;
    logic              rx_flush;
    logic              tx_pop;
    logic              rx_push;
    logic              tx_empty;
    logic              abort_any;
    logic              last_byte;
    logic [7:0]        tx_head;
    i2c_cmd_e          cmd;
    logic              cmd_valid;
    logic [7:0]        tx_byte;

    byte_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (tx_we),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .level     (tx_level)
    );

    byte_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (rx_flush),
        .push      (rx_push),
        .push_data (eng_rx),
        .pop       (rx_re),
        .head      (rx_data),
        .level     (rx_level)
    );

    assign tx_empty    = (tx_level == '0);
    assign abort_any   = abort_q | abort;
    assign cnt_nx      = cnt_q + LEN_W'(1);
    assign last_byte   = (cnt_nx == len_q);
    assign len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;

    // wait_q marks an accepted command whose eng_done is still outstanding;
    // eng_done is only honoured while it is set.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        abort_d   = abort_q;
        cnt_d     = cnt_q;
        nack_d    = nack_q;
        flag_d    = flag_q;
        done_d    = 1'b0;
        latch     = 1'b0;
        rx_flush  = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        cmd       = I2C_CMD_START;
        cmd_valid = 1'b0;
        tx_byte   = 8'h00;

        if (state_q != ST_IDLE && abort) begin
            nack_d  = 1'b1;
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    latch    = 1'b1;
                    rx_flush = 1'b1;
                    nack_d   = 1'b0;
                    flag_d   = 1'b0;
                    cnt_d    = '0;
                    wait_d   = 1'b0;
                    abort_d  = 1'b0;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                cmd = I2C_CMD_START;
                if (!wait_q) begin
                    if (abort && !eng_ready) begin
                        state_d = ST_IDLE;
                        abort_d = 1'b0;
                        done_d  = 1'b1;
                        flag_d  = 1'b1;
                    end else begin
                        cmd_valid = 1'b1;
                        wait_d    = eng_ready;
                    end
                end else if (eng_done) begin
                    wait_d  = 1'b0;
                    abort_d = 1'b0;
                    state_d = abort_any ? ST_STOP : ST_ADDR;
                end
            end

            ST_ADDR: begin
                cmd     = I2C_CMD_WRITE;
                tx_byte = addr_byte(addr_q, rw_q);
                if (!wait_q) begin
                    cmd_valid = 1'b1;
                    wait_d    = eng_ready;
                end else if (eng_done) begin
                    wait_d  = 1'b0;
                    abort_d = 1'b0;
                    if (abort_any) begin
                        state_d = ST_STOP;
                    end else if (!eng_ack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (len_q == '0) begin
                        state_d = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end

            ST_WR: begin
                cmd     = I2C_CMD_WRITE;
                tx_byte = tx_head;
                if (!wait_q) begin
                    if (tx_empty) begin
                        nack_d  = 1'b1;
                        abort_d = 1'b0;
                        state_d = ST_STOP;
                    end else begin
                        cmd_valid = 1'b1;
                        tx_pop    = eng_ready;
                        wait_d    = eng_ready;
                    end
                end else if (eng_done) begin
                    wait_d  = 1'b0;
                    abort_d = 1'b0;
                    cnt_d   = cnt_nx;
                    if (abort_any) begin
                        state_d = ST_STOP;
                    end else if (!eng_ack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (last_byte) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_RD: begin
                cmd = last_byte ? I2C_CMD_READ_NACK : I2C_CMD_READ_ACK;
                if (!wait_q) begin
                    cmd_valid = 1'b1;
                    wait_d    = eng_ready;
                end else if (eng_done) begin
                    wait_d  = 1'b0;
                    abort_d = 1'b0;
                    rx_push = 1'b1;
                    cnt_d   = cnt_nx;
                    if (abort_any || last_byte) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                cmd = I2C_CMD_STOP;
                if (!wait_q) begin
                    cmd_valid = 1'b1;
                    wait_d    = eng_ready;
                end else if (eng_done) begin
                    wait_d  = 1'b0;
                    abort_d = 1'b0;
                    done_d  = 1'b1;
                    flag_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                wait_d  = 1'b0;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            abort_q <= 1'b0;
            nack_q  <= 1'b0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            abort_q <= abort_d;
            nack_q  <= nack_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transaction parameters only matter between go and the end of STOP.
    always_ff @(posedge clk) begin
        if (latch) begin
            addr_q <= dev_addr;
            rw_q   <= rw;
            len_q  <= len_clamped;
        end
    end

    assign eng_cmd       = cmd;
    assign eng_cmd_valid = cmd_valid;
    assign eng_tx        = tx_byte;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign nack_err      = nack_q;
    assign irq           = flag_q & it_enable;

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// Randomized bench for i2c_txn_ctrl: an engine responder plus a transaction-level
// reference model of the expected command stream, status and FIFO contents.
module tb_i2c_txn_ctrl;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;
    localparam logic [2:0] C_START = 3'd0;
    localparam logic [2:0] C_WRITE = 3'd1;
    localparam logic [2:0] C_RDA   = 3'd2;
    localparam logic [2:0] C_RDN   = 3'd3;
    localparam logic [2:0] C_STOP  = 3'd4;

    typedef logic [10:0] cmd_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             go = 1'b0;
    logic             abort = 1'b0;
    logic [6:0]       dev_addr = '0;
    logic             rw = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             it_enable = 1'b0;
    logic             tx_we = 1'b0;
    logic [7:0]       tx_data = '0;
    logic             rx_re = 1'b0;
    logic [7:0]       rx_data;
    logic [LEN_W-1:0] tx_level;
    logic [LEN_W-1:0] rx_level;
    logic             busy;
    logic             done;
    logic             nack_err;
    logic             irq;
    logic [2:0]       eng_cmd;
    logic             eng_cmd_valid;
    logic [7:0]       eng_tx;
    logic             eng_ready = 1'b0;
    logic             eng_done = 1'b0;
    logic             eng_ack = 1'b0;
    logic [7:0]       eng_rx = '0;

    i2c_txn_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .abort         (abort),
        .dev_addr      (dev_addr),
        .rw            (rw),
        .len           (len),
        .it_enable     (it_enable),
        .tx_we         (tx_we),
        .tx_data       (tx_data),
        .rx_re         (rx_re),
        .rx_data       (rx_data),
        .tx_level      (tx_level),
        .rx_level      (rx_level),
        .busy          (busy),
        .done          (done),
        .nack_err      (nack_err),
        .irq           (irq),
        .eng_cmd       (eng_cmd),
        .eng_cmd_valid (eng_cmd_valid),
        .eng_tx        (eng_tx),
        .eng_ready     (eng_ready),
        .eng_done      (eng_done),
        .eng_ack       (eng_ack),
        .eng_rx        (eng_rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine configuration (written by the main flow only).
    int   stall_min = 0;
    int   stall_max = 2;
    int   dly_min = 0;
    int   dly_max = 3;
    int   nack_at = -1;
    bit   spur_en = 1'b0;
    logic [7:0] rx_fixed [DEPTH];
    int   rx_fixed_n = 0;

    // Engine observations (written by the engine only).
    cmd_t       obs[$];
    logic [7:0] rx_sent[$];
    int         stab_viol = 0;
    int         vld_viol = 0;

    int         e_st = 0;
    int         stall = 0;
    int         dly = 0;
    int         wr_idx = 0;
    int         rd_idx = 0;
    logic [2:0] cap_cmd = '0;
    logic [7:0] cap_tx = '0;
    logic       cur_ack = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            e_st = 0;
            eng_ready = 1'b0;
            eng_done = 1'b0;
            eng_ack = 1'b0;
            eng_rx = 8'h00;
        end else begin
            case (e_st)
                0: begin
                    eng_done = 1'b0;
                    if (eng_cmd_valid) begin
                        cap_cmd = eng_cmd;
                        cap_tx = eng_tx;
                        stall = stall_min + int'($urandom_range(stall_max));
                        if (stall == 0) begin
                            eng_ready = 1'b1;
                            e_st = 2;
                        end else begin
                            e_st = 1;
                        end
                    end else if (spur_en && $urandom_range(7) == 0) begin
                        eng_done = 1'b1;
                    end
                end
                1: begin
                    if (!eng_cmd_valid) begin
                        e_st = 0;
                    end else begin
                        if (eng_cmd !== cap_cmd || eng_tx !== cap_tx) stab_viol++;
                        stall--;
                        if (stall == 0) begin
                            eng_ready = 1'b1;
                            e_st = 2;
                        end
                    end
                end
                2: begin
                    eng_ready = 1'b0;
                    if (eng_cmd_valid) vld_viol++;
                    if (cap_cmd == C_START) begin
                        obs.delete();
                        rx_sent.delete();
                        wr_idx = 0;
                        rd_idx = 0;
                    end
                    obs.push_back({cap_cmd, (cap_cmd == C_WRITE) ? cap_tx : 8'h00});
                    cur_ack = 1'b1;
                    if (cap_cmd == C_WRITE) begin
                        cur_ack = (wr_idx != nack_at);
                        wr_idx++;
                    end
                    dly = dly_min + int'($urandom_range(dly_max));
                    e_st = 3;
                end
                3: begin
                    if (eng_cmd_valid) vld_viol++;
                    if (dly == 0) begin
                        eng_done = 1'b1;
                        eng_ack = cur_ack;
                        if (cap_cmd == C_RDA || cap_cmd == C_RDN) begin
                            eng_rx = (rd_idx < rx_fixed_n) ? rx_fixed[rd_idx] : 8'($urandom);
                            rx_sent.push_back(eng_rx);
                            rd_idx++;
                        end
                        e_st = 4;
                    end else begin
                        dly--;
                    end
                end
                default: begin
                    eng_done = 1'b0;
                    eng_ack = 1'b0;
                    eng_rx = 8'h00;
                    e_st = 0;
                end
            endcase
        end
    end

    // Reference model state.
    logic [7:0] tx_model[$];
    cmd_t       exp_cmds[$];
    bit         exp_nack;
    int         exp_rx_n;
    logic [7:0] push_fixed [4];
    int         pf_n = 0;
    int         stab0, vld0;

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tx_model.delete();
        @(negedge clk);
    endtask

    task automatic push_bytes(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i < pf_n) ? push_fixed[i] : 8'($urandom);
            tx_data = b;
            tx_we = 1'b1;
            if (tx_model.size() < DEPTH) tx_model.push_back(b);
            @(negedge clk);
        end
        tx_we = 1'b0;
        pf_n = 0;
    endtask

    // Expected transaction outcome from the protocol rules alone.
    task automatic model_txn(input logic [6:0] a, input logic r, input int l, input int nk);
        int lc;
        logic [7:0] b;
        lc = (l > DEPTH) ? DEPTH : l;
        exp_cmds.delete();
        exp_nack = 1'b0;
        exp_rx_n = 0;
        exp_cmds.push_back({C_START, 8'h00});
        exp_cmds.push_back({C_WRITE, a, r});
        if (nk == 0) begin
            exp_nack = 1'b1;
        end else if (lc > 0 && r) begin
            for (int i = 0; i < lc; i++) exp_cmds.push_back({(i == lc - 1) ? C_RDN : C_RDA, 8'h00});
            exp_rx_n = lc;
        end else if (lc > 0) begin
            for (int i = 1; i <= lc; i++) begin
                if (tx_model.size() == 0) begin
                    exp_nack = 1'b1;
                    break;
                end
                b = tx_model.pop_front();
                exp_cmds.push_back({C_WRITE, b});
                if (nk == i) begin
                    exp_nack = 1'b1;
                    break;
                end
            end
        end
        exp_cmds.push_back({C_STOP, 8'h00});
    endtask

    task automatic start_txn(input logic [6:0] a, input logic r, input int l, input int nk, input logic ien);
        nack_at = nk;
        it_enable = ien;
        stab0 = stab_viol;
        vld0 = vld_viol;
        dev_addr = a;
        rw = r;
        len = LEN_W'(l);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_val("busy_after_go", busy, 1);
        check_val("irq_cleared_by_go", irq, 0);
        check_val("nack_cleared_by_go", nack_err, 0);
    endtask

    task automatic wait_done(input string tag);
        int tmo = 0;
        while (!done && tmo < 3000) begin
            @(negedge clk);
            tmo++;
        end
        check_val({tag, "_done"}, done, 1);
        @(negedge clk);
        check_val({tag, "_done_width"}, done, 0);
    endtask

    task automatic finish_txn(input string tag, input logic ien);
        wait_done(tag);
        check_val({tag, "_ncmd"}, obs.size(), exp_cmds.size());
        for (int i = 0; i < exp_cmds.size() && i < obs.size(); i++)
            check_val($sformatf("%s_cmd%0d", tag, i), obs[i], exp_cmds[i]);
        check_val({tag, "_nack"}, nack_err, exp_nack);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_valid"}, eng_cmd_valid, 0);
        check_val({tag, "_irq"}, irq, ien);
        check_val({tag, "_tx_level"}, tx_level, tx_model.size());
        check_val({tag, "_rx_level"}, rx_level, exp_rx_n);
        check_val({tag, "_stable"}, stab_viol - stab0, 0);
        check_val({tag, "_valid_drop"}, vld_viol - vld0, 0);
        check_val({tag, "_rx_count"}, rx_sent.size(), exp_rx_n);
        for (int i = 0; i < exp_rx_n; i++) begin
            if (i < rx_sent.size()) check_val($sformatf("%s_rx%0d", tag, i), rx_data, rx_sent[i]);
            rx_re = 1'b1;
            @(negedge clk);
        end
        rx_re = 1'b0;
        check_val({tag, "_rx_drained"}, rx_level, 0);
    endtask

    task automatic run_txn(input string tag, input logic [6:0] a, input logic r, input int l,
                           input int npush, input int nk, input logic ien);
        push_bytes(npush);
        model_txn(a, r, l, nk);
        start_txn(a, r, l, nk, ien);
        finish_txn(tag, ien);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmo;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_nack", nack_err, 0);
        check_val("rst_irq", irq, 0);
        check_val("rst_cmd", eng_cmd, 0);
        check_val("rst_valid", eng_cmd_valid, 0);
        check_val("rst_tx", eng_tx, 0);
        check_val("rst_levels", {tx_level, rx_level}, 0);
        check_val("rst_rx_data", rx_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Write two bytes.
        push_fixed[0] = 8'hA5;
        push_fixed[1] = 8'h3C;
        pf_n = 2;
        run_txn("wr2", 7'h50, 1'b0, 2, 2, -1, 1'b0);
        check_val("wr2_addr_byte", exp_cmds[1], {C_WRITE, 8'hA0});

        // Read three bytes with known data.
        rx_fixed[0] = 8'h11;
        rx_fixed[1] = 8'h22;
        rx_fixed[2] = 8'h33;
        rx_fixed_n = 3;
        run_txn("rd3", 7'h2B, 1'b1, 3, 0, -1, 1'b0);
        rx_fixed_n = 0;

        // Address NACK with interrupt enabled.
        run_txn("anack", 7'h13, 1'b0, 2, 2, 0, 1'b1);

        // TX underrun: one byte for a three-byte write.
        apply_reset();
        run_txn("under", 7'h44, 1'b0, 3, 1, -1, 1'b0);

        // Backpressure: every command held off for at least five cycles.
        stall_min = 5;
        run_txn("bp", 7'h61, 1'b0, 3, 3, -1, 1'b0);
        stall_min = 0;

        // Abort during a WRITE data byte.
        dly_min = 4;
        push_bytes(3);
        exp_cmds.delete();
        exp_cmds.push_back({C_START, 8'h00});
        exp_cmds.push_back({C_WRITE, 7'h35, 1'b0});
        exp_cmds.push_back({C_WRITE, tx_model.pop_front()});
        exp_cmds.push_back({C_STOP, 8'h00});
        exp_nack = 1'b1;
        exp_rx_n = 0;
        start_txn(7'h35, 1'b0, 3, -1, 1'b0);
        tmo = 0;
        while (tx_level != 2 && tmo < 500) begin
            @(negedge clk);
            tmo++;
        end
        check_val("abt_wr_started", tx_level, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        finish_txn("abt_wr", 1'b0);
        dly_min = 0;

        // Abort in START before the engine accepts it.
        stall_min = 6;
        start_txn(7'h22, 1'b0, 1, -1, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("abt_start");
        check_val("abt_start_nack", nack_err, 1);
        check_val("abt_start_busy", busy, 0);
        check_val("abt_start_irq", irq, 1);
        check_val("abt_start_tx_level", tx_level, tx_model.size());
        stall_min = 0;

        // Reset in the middle of a read, then a normal transaction.
        apply_reset();
        model_txn(7'h0F, 1'b1, 4, -1);
        start_txn(7'h0F, 1'b1, 4, -1, 1'b0);
        tmo = 0;
        while (rx_level == 0 && tmo < 500) begin
            @(negedge clk);
            tmo++;
        end
        check_val("mid_rd_progress", rx_level, 1);
        reset = 1'b0;
        @(negedge clk);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_valid", eng_cmd_valid, 0);
        check_val("mid_rst_levels", {tx_level, rx_level}, 0);
        check_val("mid_rst_status", {done, nack_err}, 0);
        reset = 1'b1;
        tx_model.delete();
        @(negedge clk);
        run_txn("post_rst", 7'h5A, 1'b0, 2, 3, -1, 1'b0);

        // Randomized transactions, with stray eng_done pulses while idle.
        spur_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [6:0] a;
            logic r, ien;
            int l, np, nk;
            a = 7'($urandom);
            r = 1'($urandom);
            ien = 1'($urandom);
            l = int'($urandom_range(10));
            np = int'($urandom_range(9));
            nk = ($urandom_range(3) == 0) ? int'($urandom_range(l > DEPTH ? DEPTH : l)) : -1;
            run_txn($sformatf("rnd%0d", t), a, r, l, np, nk, ien);
        end
        spur_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
